// File: rtl/alien_fleet_controller.sv
// Alien formation sequencer: owns the alive bitmap, fleet origin and march
// direction; marches on divided enable ticks, descends at play-field edges,
// serves laser kill requests and reports CLEARED / LANDED.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for start after reset, fleet at its origin
// S_MARCH   | counting enable ticks, stepping horizontally each period
// S_DESCEND | single cycle: drop one row, reverse direction, landing test
// S_CLEARED | every alien destroyed, waiting for start
// S_LANDED  | fleet bottom reached the landing line, waiting for start
module alien_fleet_controller #(
    parameter int COLS        = 8,
    parameter int ROWS        = 4,
    parameter int ALIEN_W     = 32,
    parameter int ALIEN_H     = 16,
    parameter int X_START     = 64,
    parameter int Y_START     = 32,
    parameter int X_STEP      = 8,
    parameter int Y_STEP      = 16,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 640,
    parameter int Y_LIMIT     = 440,
    parameter int SPEED_SHIFT = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              enableStep,
    input  logic                              hitValid,
    input  logic [$clog2(ROWS)-1:0]           hitRow,
    input  logic [$clog2(COLS)-1:0]           hitCol,
    output logic                              hitAck,
    output logic                              hitKilled,
    output logic [9:0]                        xFleet,
    output logic [9:0]                        yFleet,
    output logic [ROWS*COLS-1:0]              aliveMask,
    output logic [$clog2(ROWS*COLS+1)-1:0]    aliveCount,
    output logic                              dirLeft,
    output logic                              fleetCleared,
    output logic                              fleetLanded
);

    localparam int N     = ROWS * COLS;
    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);
    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(N + 1);
    localparam int AW    = 11;

    typedef enum logic [2:0] {
        S_IDLE, S_MARCH, S_DESCEND, S_CLEARED, S_LANDED
    } state_t;

    state_t             state_q, state_d;
    logic [9:0]         x_q, x_d, y_q, y_d;
    logic               dir_q, dir_d;
    logic [CNT_W-1:0]   div_q, div_d;
    logic [N-1:0]       mask_q, mask_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ack_q, ack_d, killed_q, killed_d;

    logic [COLS-1:0]    col_any;
    logic [ROWS-1:0]    row_any;
    logic [COL_W-1:0]   left_col, right_col;
    logic [ROW_W-1:0]   bottom_row;
    logic [AW-1:0]      right_edge, left_edge, land_sum;
    logic               edge_hit, land;
    logic [CNT_W-1:0]   period_m1;
    logic               step_due, move_now;
    logic               hit_acc, in_range, kill_ok, reinit;
    logic [IDX_W-1:0]   hit_idx;

    // occupancy of each row and column from the current alive bitmap
    always_comb begin
        col_any = '0;
        row_any = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (mask_q[r*COLS+c]) begin
                    col_any[c] = 1'b1;
                    row_any[r] = 1'b1;
                end
            end
        end
    end

    // outermost alive columns and lowest alive row
    always_comb begin
        left_col   = '0;
        right_col  = '0;
        bottom_row = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (col_any[c]) left_col = COL_W'(c);
        end
        for (int c = 0; c < COLS; c++) begin
            if (col_any[c]) right_col = COL_W'(c);
        end
        for (int r = 0; r < ROWS; r++) begin
            if (row_any[r]) bottom_row = ROW_W'(r);
        end
    end

    // edge, landing and handshake decisions; edges are tested before moving
    always_comb begin
        right_edge = AW'(x_q) + (AW'(right_col) + AW'(1)) * AW'(ALIEN_W) + AW'(X_STEP);
        left_edge  = AW'(x_q) + AW'(left_col) * AW'(ALIEN_W);
        edge_hit   = dir_q ? (left_edge < AW'(X_MIN + X_STEP)) : (right_edge > AW'(X_MAX));
        land_sum   = AW'(y_q) + AW'(Y_STEP) + (AW'(bottom_row) + AW'(1)) * AW'(ALIEN_H);
        land       = (land_sum >= AW'(Y_LIMIT));
        period_m1  = CNT_W'(count_q >> SPEED_SHIFT);
        step_due   = enableStep && (state_q == S_MARCH) && (count_q != '0);
        move_now   = step_due && (div_q >= period_m1);
        hit_acc    = hitValid && !ack_q;
        in_range   = (32'(hitRow) < ROWS) && (32'(hitCol) < COLS);
        hit_idx    = IDX_W'(hitRow) * IDX_W'(COLS) + IDX_W'(hitCol);
        kill_ok    = hit_acc && in_range && mask_q[hit_idx] &&
                     ((state_q == S_MARCH) || (state_q == S_DESCEND));
        reinit     = start && ((state_q == S_IDLE) || (state_q == S_CLEARED) ||
                               (state_q == S_LANDED));
    end

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // next state; an empty fleet outranks moving, descending and landing
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_CLEARED, S_LANDED: begin
                if (start) state_d = S_MARCH;
            end
            S_MARCH: begin
                if (count_q == '0)             state_d = S_CLEARED;
                else if (move_now && edge_hit) state_d = S_DESCEND;
            end
            S_DESCEND: begin
                if (count_q == '0) state_d = S_CLEARED;
                else if (land)     state_d = S_LANDED;
                else               state_d = S_MARCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // datapath next values; a move sees the pre-kill mask, both take effect
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        dir_d    = dir_q;
        div_d    = div_q;
        mask_d   = mask_q;
        count_d  = count_q;
        ack_d    = hit_acc;
        killed_d = kill_ok;
        if (reinit) begin
            x_d     = 10'(X_START);
            y_d     = 10'(Y_START);
            dir_d   = 1'b0;
            div_d   = '0;
            mask_d  = '1;
            count_d = CNT_W'(N);
        end else begin
            if (step_due) begin
                if (move_now) begin
                    div_d = '0;
                    if (!edge_hit) x_d = dir_q ? (x_q - 10'(X_STEP)) : (x_q + 10'(X_STEP));
                end else begin
                    div_d = div_q + CNT_W'(1);
                end
            end
            if ((state_q == S_DESCEND) && (count_q != '0)) begin
                y_d   = y_q + 10'(Y_STEP);
                dir_d = ~dir_q;
            end
            if (kill_ok) begin
                mask_d[hit_idx] = 1'b0;
                count_d         = count_q - CNT_W'(1);
            end
        end
    end

    // datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q      <= 10'(X_START);
            y_q      <= 10'(Y_START);
            dir_q    <= 1'b0;
            div_q    <= '0;
            mask_q   <= '1;
            count_q  <= CNT_W'(N);
            ack_q    <= 1'b0;
            killed_q <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            dir_q    <= dir_d;
            div_q    <= div_d;
            mask_q   <= mask_d;
            count_q  <= count_d;
            ack_q    <= ack_d;
            killed_q <= killed_d;
        end
    end

    // outputs
    always_comb begin
        fleetCleared = (state_q == S_CLEARED);
        fleetLanded  = (state_q == S_LANDED);
        hitAck       = ack_q;
        hitKilled    = killed_q;
        xFleet       = x_q;
        yFleet       = y_q;
        aliveMask    = mask_q;
        aliveCount   = count_q;
        dirLeft      = dir_q;
    end

endmodule

// File: tb/tb_alien_fleet_controller.sv
// Bench for alien_fleet_controller: directed scenarios plus a random mix of
// march ticks and kill requests checked against a cell-level fleet model.
module tb_alien_fleet_controller;

    localparam int ROWS = 4;
    localparam int COLS = 8;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, enableStep, hitValid;
    logic [1:0]  hitRow;
    logic [2:0]  hitCol;
    logic        hitAck, hitKilled, dirLeft, fleetCleared, fleetLanded;
    logic [9:0]  xFleet, yFleet;
    logic [31:0] aliveMask;
    logic [5:0]  aliveCount;

    logic        start_l, step_l, hv_l;
    logic [1:0]  row_l;
    logic [2:0]  col_l;
    logic        ack_l, killed_l, dir_l, cleared_l, landed_l;
    logic [9:0]  x_l, y_l;
    logic [31:0] mask_l;
    logic [5:0]  count_l;

    alien_fleet_controller dut (
        .clk(clk), .reset(reset), .start(start), .enableStep(enableStep),
        .hitValid(hitValid), .hitRow(hitRow), .hitCol(hitCol),
        .hitAck(hitAck), .hitKilled(hitKilled), .xFleet(xFleet), .yFleet(yFleet),
        .aliveMask(aliveMask), .aliveCount(aliveCount), .dirLeft(dirLeft),
        .fleetCleared(fleetCleared), .fleetLanded(fleetLanded));

    alien_fleet_controller #(.Y_LIMIT(100)) dut_l (
        .clk(clk), .reset(reset), .start(start_l), .enableStep(step_l),
        .hitValid(hv_l), .hitRow(row_l), .hitCol(col_l),
        .hitAck(ack_l), .hitKilled(killed_l), .xFleet(x_l), .yFleet(y_l),
        .aliveMask(mask_l), .aliveCount(count_l), .dirLeft(dir_l),
        .fleetCleared(cleared_l), .fleetLanded(landed_l));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // fleet model: mode 0 idle, 1 active, 2 cleared, 3 landed
    int m_x, m_y, m_dir, m_div, m_mode;
    bit alive [ROWS][COLS];

    function automatic int m_count();
        int n = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                n += int'(alive[r][c]);
        return n;
    endfunction

    function automatic logic [31:0] m_mask();
        logic [31:0] m = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                m[r*COLS+c] = alive[r][c];
        return m;
    endfunction

    task automatic m_extents(output int l, output int rt, output int b);
        l = COLS; rt = -1; b = -1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (alive[r][c]) begin
                    if (c < l) l = c;
                    if (c > rt) rt = c;
                    if (r > b) b = r;
                end
    endtask

    task automatic m_reinit();
        m_x = 64; m_y = 32; m_dir = 0; m_div = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                alive[r][c] = 1'b1;
    endtask

    task automatic m_pulse(output bit desc);
        int period, l, rt, b;
        desc = 1'b0;
        if (m_mode != 1) return;
        period = m_count() / 8 + 1;
        m_div++;
        if (m_div >= period) begin
            m_div = 0;
            m_extents(l, rt, b);
            if (m_dir == 0) begin
                if (m_x + (rt + 1) * 32 + 8 > 640) desc = 1'b1;
                else m_x += 8;
            end else begin
                if (m_x + l * 32 < 8) desc = 1'b1;
                else m_x -= 8;
            end
        end
    endtask

    task automatic m_kill(input int r, input int c, output bit k);
        k = (m_mode == 1) && alive[r][c];
        if (k) alive[r][c] = 1'b0;
        if (m_mode == 1 && m_count() == 0) m_mode = 2;
    endtask

    task automatic m_descend();
        int l, rt, b;
        if (m_mode != 1) return;
        m_y += 16;
        m_dir ^= 1;
        m_extents(l, rt, b);
        if (m_y + (b + 1) * 16 >= 440) m_mode = 3;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".x"}, xFleet, m_x);
        chk({tag, ".y"}, yFleet, m_y);
        chk({tag, ".dir"}, dirLeft, m_dir);
        chk({tag, ".mask"}, aliveMask, m_mask());
        chk({tag, ".count"}, aliveCount, m_count());
        chk({tag, ".cleared"}, fleetCleared, m_mode == 2);
        chk({tag, ".landed"}, fleetLanded, m_mode == 3);
    endtask

    // one tick followed by one quiet cycle so any descent has completed
    task automatic op_pulse();
        bit desc;
        @(negedge clk); enableStep = 1'b1;
        @(negedge clk); enableStep = 1'b0;
        @(negedge clk);
        m_pulse(desc);
        if (desc) m_descend();
        check_state("pulse");
    endtask

    task automatic op_kill(input int r, input int c, input bit with_pulse);
        bit desc, k;
        @(negedge clk);
        hitValid = 1'b1; hitRow = 2'(r); hitCol = 3'(c); enableStep = with_pulse;
        @(negedge clk);
        enableStep = 1'b0;
        desc = 1'b0;
        if (with_pulse) m_pulse(desc);
        m_kill(r, c, k);
        chk("kill.ack", hitAck, 1);
        chk("kill.killed", hitKilled, k);
        chk("kill.mask", aliveMask, m_mask());
        chk("kill.count", aliveCount, m_count());
        hitValid = 1'b0;
        @(negedge clk);
        if (desc) m_descend();
        chk("kill.ack_drop", hitAck, 0);
        check_state("kill");
    endtask

    task automatic op_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        m_reinit();
        m_mode = 1;
        check_state("start");
    endtask

    initial begin
        int xmax;
        bit seen_right, done;
        reset = 1'b0; start = 1'b0; enableStep = 1'b0; hitValid = 1'b0;
        hitRow = '0; hitCol = '0;
        start_l = 1'b0; step_l = 1'b0; hv_l = 1'b0; row_l = '0; col_l = '0;
        m_reinit();
        m_mode = 0;

        // reset values, then idle ignores ticks and refuses kills
        repeat (2) @(negedge clk);
        check_state("in_reset");
        reset = 1'b1;
        @(negedge clk);
        check_state("after_reset");
        chk("rst.ack", hitAck, 0);
        chk("rst.killed", hitKilled, 0);
        chk("rst.mask_full", aliveMask, 32'hFFFF_FFFF);
        chk("rst_l.y", y_l, 32);
        repeat (3) op_pulse();
        op_kill(0, 0, 1'b0);

        // march to the right edge at period 5
        op_start();
        repeat (5) op_pulse();
        chk("x_after_5", xFleet, 72);
        repeat (195) op_pulse();
        chk("x_after_200", xFleet, 384);
        repeat (5) op_pulse();
        chk("desc.y", yFleet, 48);
        chk("desc.dir", dirLeft, 1);
        repeat (5) op_pulse();
        chk("x_left_step", xFleet, 376);

        // single kill and repeated kill of the same alien
        op_kill(1, 3, 1'b0);
        chk("bit11", aliveMask[11], 0);
        chk("count31", aliveCount, 31);
        op_kill(1, 3, 1'b0);

        // narrower fleet reaches further right
        for (int r = 0; r < ROWS; r++)
            for (int c = 5; c < COLS; c++)
                op_kill(r, c, 1'b0);
        xmax = 0; seen_right = 1'b0; done = 1'b0;
        for (int i = 0; i < 1000 && !done; i++) begin
            op_pulse();
            if (dirLeft == 1'b0) begin
                seen_right = 1'b1;
                if (int'(xFleet) > xmax) xmax = int'(xFleet);
            end else if (seen_right) begin
                done = 1'b1;
            end
        end
        chk("right_sweep_done", done, 1);
        chk("xmax_narrow", xmax, 480);

        // random mix of ticks, kills and simultaneous kill+tick
        for (int i = 0; i < 200; i++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 8) op_pulse();
            else op_kill(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), sel == 9);
        end

        // wipe out the fleet, ticks ignored while cleared, then restart
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                op_kill(r, c, 1'b0);
        chk("cleared", fleetCleared, 1);
        op_pulse();
        op_start();
        chk("restart.count", aliveCount, 32);

        // low landing line: first descent lands
        @(negedge clk); start_l = 1'b1;
        @(negedge clk); start_l = 1'b0;
        for (int i = 0; i < 205; i++) begin
            @(negedge clk); step_l = 1'b1;
        end
        @(negedge clk); step_l = 1'b0;
        @(negedge clk);
        chk("land.y", y_l, 48);
        chk("land.flag", landed_l, 1);
        chk("land.x", x_l, 384);
        chk("land.dir", dir_l, 1);
        @(negedge clk); step_l = 1'b1;
        @(negedge clk); step_l = 1'b0;
        @(negedge clk);
        chk("landed_hold.x", x_l, 384);
        @(negedge clk); start_l = 1'b1;
        @(negedge clk); start_l = 1'b0;
        chk("relaunch.landed", landed_l, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); step_l = 1'b1;
        end
        @(negedge clk); step_l = 1'b0;
        chk("relaunch.x", x_l, 72);

        // asynchronous reset mid-march
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst.x", x_l, 64);
        chk("arst.y", y_l, 32);
        chk("arst.mask", mask_l, 32'hFFFF_FFFF);
        chk("arst.count", count_l, 32);
        chk("arst.flags", {ack_l, killed_l, dir_l, cleared_l, landed_l}, 0);
        m_reinit();
        m_mode = 0;
        check_state("arst_main");
        @(negedge clk); reset = 1'b1;
        @(negedge clk); step_l = 1'b1;
        @(negedge clk); step_l = 1'b0;
        repeat (5) @(negedge clk);
        chk("arst_idle.x", x_l, 64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
